// File: rtl/axil_pkg.sv
// axil_pkg: FSM states, AXI response codes and parameter checks for axil_master
package axil_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    function automatic bit data_w_ok(input int w);
        return w == 32 || w == 64;
    endfunction
endpackage

// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite master fed by a valid/ready command port
module axil_master
    import axil_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [2:0]          ARPROT,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [2:0]          AWPROT,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("axil_master: DATA_W must be 32 or 64");
    end

    state_t state, state_n;
    logic   aw_done, w_done, aw_done_n, w_done_n;

    assign ARPROT = PROT;
    assign AWPROT = PROT;

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                if (cmd_valid && cmd_ready) state_n = cmd_write ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: if (ARVALID && ARREADY) state_n = RD_DATA;
            RD_DATA: if (RVALID) state_n = RESP;
            WR_REQ: begin
                aw_done_n = aw_done | (AWVALID & AWREADY);
                w_done_n  = w_done | (WVALID & WREADY);
                if (aw_done_n && w_done_n) state_n = WR_RESP;
            end
            WR_RESP: if (BVALID) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Every handshake output is registered from the next state, so it lines up with state entry.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cmd_ready <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            ARADDR    <= '0;
            AWADDR    <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            state     <= state_n;
            aw_done   <= aw_done_n;
            w_done    <= w_done_n;
            cmd_ready <= state_n == IDLE;
            ARVALID   <= state_n == RD_ADDR;
            RREADY    <= state_n == RD_DATA;
            AWVALID   <= state_n == WR_REQ && !aw_done_n;
            WVALID    <= state_n == WR_REQ && !w_done_n;
            BREADY    <= state_n == WR_RESP;
            rsp_valid <= state_n == RESP;
            if (cmd_valid && cmd_ready) begin
                ARADDR    <= cmd_addr;
                AWADDR    <= cmd_addr;
                WDATA     <= cmd_wdata;
                WSTRB     <= cmd_wstrb;
                rsp_write <= cmd_write;
            end
            if (state == RD_DATA && RVALID) begin
                rsp_rdata <= RDATA;
                rsp_resp  <= RRESP;
            end
            if (state == WR_RESP && BVALID) begin
                rsp_rdata <= '0;
                rsp_resp  <= BRESP;
            end
        end
    end
endmodule

// File: doc/axil_master.md
# axil_master

Parametrised single-outstanding AXI4-Lite master that replaces the fixed 32-bit read/write master in the memory path. It accepts one command at a time from the CPU-side load/store unit on a valid/ready command port and runs the AW/W/B or AR/R channel sequence. It returns read data and the AXI response code on a valid/ready response port. AW and W handshakes are tracked independently, and byte strobes, PROT and RRESP/BRESP are supported.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 or 64
- PROT, 3'b000, constant driven on ARPROT/AWPROT
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  byte enables (writes only)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured RRESP/BRESP
- ARADDR out ADDR_W; ARVALID out 1; ARREADY in 1; ARPROT out 3
- RDATA in DATA_W; RRESP in 2; RVALID in 1; RREADY out 1
- AWADDR out ADDR_W; AWVALID out 1; AWREADY in 1; AWPROT out 3
- WDATA out DATA_W; WSTRB out DATA_W/8; WVALID out 1; WREADY in 1
- BRESP in 2; BVALID in 1; BREADY out 1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: cmd_ready = 1. This is the only state with cmd_ready high.
  - On cmd_valid, latch addr, wdata, wstrb and write.
  - Read → RD_ADDR. Write → WR_REQ.
- RD_ADDR: ARVALID = 1 with the latched address. On ARVALID & ARREADY → RD_DATA. R-channel signals are ignored in this state.
- RD_DATA: RREADY = 1. On RVALID → capture RDATA and RRESP, then → RESP.
- WR_REQ: AWVALID and WVALID assert together on entry.
  - Each VALID drops independently after its own handshake, tracked by aw_done and w_done flags.
  - When both handshakes are done (including the same cycle) → WR_RESP.
  - BVALID arriving in WR_REQ is ignored.
- WR_RESP: BREADY = 1. On BVALID → capture BRESP and set rdata to 0, then → RESP.
- RESP: rsp_valid = 1. Outputs are held stable until rsp_ready, then → IDLE.
- Non-OKAY RRESP/BRESP is passed through unchanged. The FSM does not retry.
- VALID signals never drop before their handshake completes.
- All AXI outputs and rsp_* are registered.
- ARPROT and AWPROT are constant PROT.

## Timing
- Reset values: all VALID/READY outputs 0; ARADDR, AWADDR, WDATA, WSTRB, rsp_rdata and rsp_resp 0; state IDLE. cmd_ready is 0 during reset and 1 from the first cycle after release.
- Reset asserted mid-transaction aborts immediately. All outputs return to reset values asynchronously. No response is generated.
- Zero-wait read: command handshake at cycle 0 → ARVALID cycle 1 → RREADY cycle 2 with RVALID → rsp_valid cycle 3. Minimum latency 3 cycles.
- Zero-wait write: AW and W handshakes in cycle 1 → BREADY cycle 2 → rsp_valid cycle 3.
- Throughput: one command per 4 cycles at best. The next cmd_ready rises the cycle after the rsp handshake.
- Slave backpressure stalls the FSM indefinitely. There is no timeout.

## Structure
- Package axil_pkg:
  - state enum;
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - DATA_W legality check function.
- Single module with no sub-module. The AW/W done-flag pair is inline logic.

## Test plan
- Read, zero-wait slave: addr 0x1000, RDATA 0xDEADBEEF → rsp_valid at cycle 3, rsp_rdata 0xDEADBEEF, rsp_resp 00, rsp_write 0.
- Write with WREADY 3 cycles after AWREADY: addr 0x2004, data 0x12345678, strb 4'b0011 → AWVALID drops after 1 cycle, WVALID drops after 4 cycles, BREADY rises only after both; rsp_resp 00.
- Write with W accepted before AW: WREADY at cycle 1, AWREADY at cycle 5 → single B phase; WSTRB/WDATA unchanged until the W handshake.
- Error response: RRESP=2'b10 on a read → rsp_resp 10, rsp_rdata = RDATA; next command accepted normally.
- Response backpressure: rsp_ready held low for 10 cycles → rsp_* stable, cmd_ready 0 throughout, cmd_valid ignored.
- Reset mid-transaction: ARESETN low while in RD_DATA → RREADY and all outputs 0 asynchronously; after release, cmd_ready 1 and a fresh read completes correctly.
